// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: boot-phase loader ownership, then loader/fetch sharing with a fetch starvation guard.
// Optional IMEM_WRITE_COUNT_EN adds a saturating loader-write counter output ld_wr_count.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  input  logic              ld_done,
  output logic              core_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_WRITE_COUNT_EN
  ,
  output logic [15:0]       ld_wr_count
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {BOOT, RUN} state_t;

  state_t             state_q;
  logic               core_hold_q;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic               fetch_valid_q;
  logic [DATA_W-1:0]  inst_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               fetch_gnt;
  logic               burst_max;

  // Grant selection and burst counter next-state
  always_comb begin
    fetch_gnt   = 1'b0;
    ld_gnt      = 1'b0;
    fetch_stall = 1'b1;
    burst_d     = '0;
    burst_max   = (burst_q == CNT_W'(MAX_LD_BURST));
    case (state_q)
      BOOT: begin
        ld_gnt = ld_req;
      end
      RUN: begin
        fetch_gnt   = fetch_req & (~ld_req | burst_max);
        ld_gnt      = ld_req & ~fetch_gnt;
        fetch_stall = fetch_req & ~fetch_gnt;
        if (!fetch_req || fetch_gnt) begin
          burst_d = '0;
        end else if (ld_gnt && !burst_max) begin
          burst_d = burst_q + CNT_W'(1);
        end else begin
          burst_d = burst_q;
        end
      end
      default: ;
    endcase
  end

  // Memory port drive; address and write data hold when the port is idle
  always_comb begin
    mem_en    = ld_gnt | fetch_gnt;
    mem_we    = ld_gnt;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      core_hold_q   <= 1'b1;
      burst_q       <= '0;
      fetch_valid_q <= 1'b0;
      inst_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          if (ld_done) begin
            state_q     <= RUN;
            core_hold_q <= 1'b0;
          end
        end
        RUN: ;
        default: begin
          state_q     <= BOOT;
          core_hold_q <= 1'b1;
        end
      endcase
      burst_q       <= burst_d;
      fetch_valid_q <= fetch_gnt;
      if (fetch_valid_q) inst_q  <= mem_rdata;
      if (mem_en)        addr_q  <= mem_addr;
      if (ld_gnt)        wdata_q <= ld_data;
    end
  end

  // Read data arrives the cycle after the fetch grant; hold it afterwards
  assign fetch_inst  = fetch_valid_q ? mem_rdata : inst_q;
  assign fetch_valid = fetch_valid_q;
  assign core_hold   = core_hold_q;

`ifdef IMEM_WRITE_COUNT_EN
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
    end else if (ld_gnt && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign ld_wr_count = wr_cnt_q;
`endif

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Single-port instruction-memory controller placed between the fetch/PC stage, a program loader, and the instruction memory.
- Holds the core in a boot phase while the loader writes the program image.
- After boot, shares the memory port between loader writes and instruction fetches, with a starvation guard for fetch.
- Drives `fetch_stall` so the PC register holds its value whenever fetch is not granted.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- MAX_LD_BURST, 4, maximum consecutive loader grants in RUN while fetch is waiting (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch wants an instruction at fetch_addr
- fetch_addr  in  ADDR_W  byte address from the PC
- fetch_stall  out  1  PC must hold this cycle
- fetch_valid  out  1  fetch_inst valid (one cycle after fetch grant)
- fetch_inst  out  DATA_W  fetched instruction
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader byte address
- ld_data  in  DATA_W  loader write data
- ld_gnt  out  1  loader write accepted this cycle
- ld_done  in  1  single-cycle pulse: boot image complete
- core_hold  out  1  core held in boot phase
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, synchronous, 1-cycle latency

Behaviour:
- FSM states: BOOT, RUN. Reset enters BOOT.
- Reset values of registered outputs:
  - fetch_valid=0, fetch_inst=0
  - core_hold=1
  - burst counter=0
  - fetch_stall=1
- Grant logic is combinational from the current state, counter and requests. Only one grant may be active per cycle.
- BOOT state:
  - ld_gnt=ld_req; fetch is never granted; fetch_stall=1; core_hold=1.
  - ld_done=1 moves the FSM to RUN next cycle. A write requested in the same cycle is still granted.
  - ld_done has no effect in RUN.
- RUN state:
  - core_hold=0.
  - Loader has priority unless burst counter==MAX_LD_BURST and fetch_req=1; in that case fetch wins and the counter clears.
  - Counter increments on each loader grant while fetch_req=1, saturates at MAX_LD_BURST, and clears on any fetch grant or any cycle with fetch_req=0.
  - fetch_stall = fetch_req & ~fetch_gnt. It is 0 when fetch_req=0.
- Memory drive:
  - Loader grant: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data.
  - Fetch grant: mem_en=1, mem_we=0, mem_addr=fetch_addr.
  - No grant: mem_en=0, mem_we=0; mem_addr and mem_wdata hold the last value.
- Fetch response: fetch_valid registers fetch_gnt. When fetch_valid=1, fetch_inst=mem_rdata; otherwise fetch_inst holds its value.
- Fetch address alignment: fetch_addr[1:0] are ignored. mem_addr receives the full byte address.
- Reset mid-operation:
  - Returns to BOOT immediately.
  - Drops fetch_valid; an in-flight read is discarded.
  - Raises core_hold.
- Simultaneous ld_req and fetch_req in BOOT: loader only.

Optional Feature:
- Macro: IMEM_WRITE_COUNT_EN.
- When defined: adds output `ld_wr_count` [15:0].
  - Counts loader grants in all states and saturates at 16'hFFFF.
  - Reset value 0; not cleared by the BOOT->RUN transition.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Boot load: after reset, 3 ld_req writes at 0x0/0x4/0x8, then ld_done. Required: ld_gnt=1 each cycle; core_hold=1 and fetch_stall=1 throughout, even with fetch_req=1; core_hold=0 in the cycle after ld_done.
- Fetch path in RUN: fetch_req=1, fetch_addr=0x4, mem_rdata=0x00500093. Required: mem_we=0 and mem_addr=0x4 with fetch_stall=0; one cycle later fetch_valid=1 and fetch_inst=0x00500093.
- Starvation guard: MAX_LD_BURST=4, ld_req and fetch_req held at 1 in RUN. Required: 4 loader grants, then 1 fetch grant with fetch_stall=0, repeating; fetch_stall=1 during the loader cycles.
- Idle: no requests in RUN. Required: mem_en=0, fetch_stall=0, fetch_valid=0 next cycle.
- Reset mid-fetch: assert reset while a fetch grant is outstanding. Required: fetch_valid=0 and core_hold=1 asynchronously; FSM in BOOT after deassertion; ld_done ignored once in RUN.
- IMEM_WRITE_COUNT_EN defined: 5 boot writes plus 2 RUN writes. Required: ld_wr_count=7; reset returns it to 0.
